codificador_inmediato: RTL and testbench

- Sequential inverse of the immediate sign-extension path: takes a 32-bit constant and a destination register, and emits the minimal RV32I sequence (ADDI, LUI, or LUI+ADDI) that loads it.
- Sits between the boot/debug loader and instruction memory/fetch injection.
- Emitted instructions, decoded by the core's immediate extension (12-bit sign-extend or 20-bit upper), must reproduce the constant exactly.

---
 rtl/codificador_inmediato.sv | 91 +++++++++
 tb/tb_codificador_inmediato.sv | 132 +++++++++++++
 2 files changed

// File: rtl/codificador_inmediato.sv
// codificador_inmediato: turns a 32-bit constant plus rd into the shortest ADDI / LUI / LUI+ADDI load sequence.
// Optional self-check of the emitted words behind CODIFICADOR_AUTOCHEQUEO_EN (adds chk_err).
module codificador_inmediato #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [4:0]      req_rd,
   input  logic [XLEN-1:0] req_value,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic            instr_last
`ifdef CODIFICADOR_AUTOCHEQUEO_EN
   ,
   output logic            chk_err
`endif
);
   typedef enum logic [1:0] {IDLE, EMIT_ONE, EMIT_LUI, EMIT_ADDI} state_t;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   state_t state_q, state_d;
   logic [XLEN-1:0] w0_q, w1_q;
   logic [XLEN-1:0] first_w, lui_w, addi_x0_w, addi_rd_w;
   logic [19:0] hi;
   logic [11:0] lo;
   logic fits12, single, accept, xfer;
   // hi absorbs the borrow that ADDI's sign extension of lo will subtract later
   always_comb begin
      fits12    = (&req_value[31:11]) | ~(|req_value[31:11]);
      lo        = req_value[11:0];
      hi        = req_value[31:12] + {19'd0, req_value[11]};
      lui_w     = {hi, req_rd, OP_LUI};
      addi_x0_w = {lo, 5'd0, 3'b000, req_rd, OP_IMM};
      addi_rd_w = {lo, req_rd, 3'b000, req_rd, OP_IMM};
      single    = (req_rd == 5'd0) | fits12 | (lo == 12'd0);
      first_w   = (req_rd == 5'd0) ? 32'h0000_0013 : fits12 ? addi_x0_w : lui_w;
   end
   always_comb begin
      req_ready   = state_q == IDLE;
      instr_valid = state_q != IDLE;
      instr       = (state_q == IDLE) ? '0 : (state_q == EMIT_ADDI) ? w1_q : w0_q;
      instr_last  = instr_valid && state_q != EMIT_LUI;
      accept      = req_valid & req_ready;
      xfer        = instr_valid & instr_ready;
      state_d     = accept ? (single ? EMIT_ONE : EMIT_LUI) :
                    !xfer ? state_q :
                    (state_q == EMIT_LUI) ? EMIT_ADDI : IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         w0_q    <= '0;
         w1_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            w0_q <= first_w;
            w1_q <= addi_rd_w;
         end
      end
   end
`ifdef CODIFICADOR_AUTOCHEQUEO_EN
   logic [XLEN-1:0] value_q, acc_q, decoded;
   logic [4:0] rd_q;
   // ADDI reading x0 starts from zero; ADDI reading rd adds onto the LUI base
   always_comb begin
      decoded = (instr[6:0] == OP_LUI) ? {instr[31:12], 12'd0} :
                {{20{instr[31]}}, instr[31:20]} + ((instr[19:15] == 5'd0) ? '0 : acc_q);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= '0;
         acc_q   <= '0;
         rd_q    <= '0;
         chk_err <= 1'b0;
      end else begin
         if (accept) begin
            value_q <= req_value;
            rd_q    <= req_rd;
         end
         if (xfer) begin
            acc_q <= decoded;
            if (instr_last && rd_q != 5'd0 && decoded != value_q) chk_err <= 1'b1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_codificador_inmediato.sv
// tb_codificador_inmediato: directed scoreboard bench for the constant-load encoder.
module tb_codificador_inmediato;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic req_valid = 1'b0;
   logic req_ready;
   logic [4:0] req_rd = '0;
   logic [31:0] req_value = '0;
   logic instr_valid;
   logic instr_ready = 1'b1;
   logic [31:0] instr;
   logic instr_last;
`ifdef CODIFICADOR_AUTOCHEQUEO_EN
   logic chk_err;
`endif
   int total = 0;
   int bad = 0;
   logic [32:0] sb[$];

   codificador_inmediato dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_rd(req_rd), .req_value(req_value), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_last(instr_last)
`ifdef CODIFICADOR_AUTOCHEQUEO_EN
      , .chk_err(chk_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] v, input logic [4:0] r, input int n,
                       input logic [31:0] w0, input logic [31:0] w1);
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("req_ready_wait", {31'd0, req_ready}, 32'd1);
      sb.push_back({w0, n == 1});
      if (n == 2) sb.push_back({w1, 1'b1});
      req_valid = 1'b1;
      req_value = v;
      req_rd = r;
      @(posedge clk);
      #1 req_valid = 1'b0;
      check("latency_valid", {31'd0, instr_valid}, 32'd1);
   endtask

   task automatic drain();
      int g = 0;
      logic [32:0] e;
      while (sb.size() > 0 && g < 50) begin
         @(negedge clk);
         g++;
         if (instr_valid && instr_ready) begin
            e = sb.pop_front();
            check("instr", instr, e[32:1]);
            check("instr_last", {31'd0, instr_last}, {31'd0, e[0]});
         end
      end
      check("drain_left", sb.size(), 32'd0);
      @(negedge clk);
      check("ready_after", {31'd0, req_ready}, 32'd1);
      check("idle_valid", {31'd0, instr_valid}, 32'd0);
`ifdef CODIFICADOR_AUTOCHEQUEO_EN
      check("chk_err", {31'd0, chk_err}, 32'd0);
`endif
   endtask

   initial begin
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_instr", instr, 32'h0000_0000);
      check("rst_instr_last", {31'd0, instr_last}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send(32'h0000_0005, 5'd1, 1, 32'h0050_0093, 32'h0);
      drain();
      send(32'hFFFF_F800, 5'd2, 1, 32'h8000_0113, 32'h0);
      drain();
      send(32'h1234_5000, 5'd3, 1, 32'h1234_51B7, 32'h0);
      drain();
      send(32'h1234_5800, 5'd5, 2, 32'h1234_62B7, 32'h8002_8293);
      drain();
      send(32'h1234_5678, 5'd0, 1, 32'h0000_0013, 32'h0);
      drain();
      send(32'h0000_0800, 5'd4, 2, 32'h0000_1237, 32'h8002_0213);
      drain();
      send(32'h0000_07FF, 5'd6, 1, 32'h7FF0_0313, 32'h0);
      drain();
      // stall the LUI word, then reset while the ADDI is pending
      instr_ready = 1'b0;
      send(32'h1234_5800, 5'd5, 2, 32'h1234_62B7, 32'h8002_8293);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", {31'd0, instr_valid}, 32'd1);
         check("stall_instr", instr, 32'h1234_62B7);
         check("stall_last", {31'd0, instr_last}, 32'd0);
      end
      instr_ready = 1'b1;
      check("stall_sb_lui", instr, sb[0][32:1]);
      void'(sb.pop_front());
      @(posedge clk);
      #1 instr_ready = 1'b0;
      check("addi_pending", instr, sb[0][32:1]);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_instr", instr, 32'h0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
